// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: instruction formats, major opcodes, the buffered
// word record, and the field packing / immediate range rules.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'b000,
    FMT_S    = 3'b001,
    FMT_B    = 3'b010,
    FMT_U    = 3'b011,
    FMT_J    = 3'b100,
    FMT_R    = 3'b101,
    FMT_RSV6 = 3'b110,
    FMT_RSV7 = 3'b111
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } enc_word_t;

  // True when every bit of the slice imm[31:lo] carries the same value, i.e.
  // the immediate survives truncation to the encoded width plus sign.
  function automatic logic sext_ok(input logic [31:0] imm, input int unsigned lo);
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b >= lo) begin
        all_one  = all_one & imm[b];
        all_zero = all_zero & ~imm[b];
      end
    end
    return all_one | all_zero;
  endfunction

  function automatic logic fmt_legal(input fmt_e fmt, input logic [31:0] imm);
    logic ok;
    ok = 1'b0;
    case (fmt)
      FMT_I, FMT_S: ok = sext_ok(imm, 11);
      FMT_B:        ok = sext_ok(imm, 12) & ~imm[0];
      FMT_U:        ok = (imm[11:0] == 12'h000);
      FMT_J:        ok = sext_ok(imm, 20) & ~imm[0];
      FMT_R:        ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode_word(
    input fmt_e        fmt,
    input logic [6:0]  opcode,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = 32'h0;
    case (fmt)
      FMT_R: w = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: w = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: w = {imm[31:12], rd, opcode};
      FMT_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-set input handshake, encoded-word output handshake and error status
// of the instruction encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  err_count;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_count
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_count
  );
endinterface

// File: rtl/instr_enc_fifo.sv
// DEPTH-entry FIFO of {addr, instr} words with occupancy and full/empty flags.
module instr_enc_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  enc_word_t        wdata_i,
  input  logic             pop_i,
  output enc_word_t        rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  enc_word_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = bump(wr_ptr_q);
    if (pop_i)  rd_ptr_d = bump(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded field sets into 32-bit RISC-V words, tags each legal word with
// a running address and buffers it; illegal sets are dropped and counted.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic        alive_q;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  fmt_e             fmt;
  logic             legal;
  logic             in_ready;
  logic             accept;
  logic             push;
  logic             pop;
  logic             bad;
  enc_word_t        wr_word;
  enc_word_t        rd_word;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  // alive_q holds in_ready low through reset and releases it on the first clock after.
  assign in_ready = alive_q & ~full;

  always_comb begin
    fmt           = fmt_e'(bus.in_fmt);
    legal         = fmt_legal(fmt, bus.in_imm);
    accept        = bus.in_valid & in_ready;
    push          = accept & legal;
    bad           = accept & ~legal;
    pop           = ~empty & bus.out_ready;
    wr_word.addr  = addr_q;
    wr_word.instr = encode_word(fmt, bus.in_opcode, bus.in_funct3, bus.in_funct7,
                                bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
    addr_d        = push ? addr_q + 32'd4 : addr_q;
    err_d         = bad;
    err_cnt_d     = (bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q   <= 1'b0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      alive_q   <= 1'b1;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  instr_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_word),
    .pop_i   (pop),
    .rdata_o (rd_word),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ~empty;
  assign bus.out_instr = rd_word.instr;
  assign bus.out_addr  = rd_word.addr;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full) && (count <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized field
// sets compared each cycle against an arithmetic reference model.
module tb_instr_encoder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic clk;
  logic rst_n;
  instr_encoder_if bus ();

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit [63:0]   m_q [$];
  bit [31:0]   m_addr;
  int          m_errs;
  bit          m_err;
  bit          m_alive;
  bit          m_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit [31:0] bits(input bit [31:0] v, input int lo, input int n);
    return (v >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  function automatic bit ref_legal(input int fmt, input bit [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (fmt)
      0, 1: return s >= -2048 && s <= 2047;
      2:    return s >= -4096 && s <= 4095 && imm % 2 == 0;
      3:    return imm % 4096 == 0;
      4:    return s >= -(64'sd1 << 20) && s < (64'sd1 << 20) && imm % 2 == 0;
      5:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [31:0] ref_encode(input int fmt, input bit [31:0] op, input bit [31:0] f3,
                                           input bit [31:0] f7, input bit [31:0] rd, input bit [31:0] rs1,
                                           input bit [31:0] rs2, input bit [31:0] imm);
    case (fmt)
      5: return f7 << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op;
      0: return bits(imm, 0, 12) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op;
      1: return bits(imm, 5, 7) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | bits(imm, 0, 5) << 7 | op;
      2: return bits(imm, 12, 1) << 31 | bits(imm, 5, 6) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12
              | bits(imm, 1, 4) << 8 | bits(imm, 11, 1) << 7 | op;
      3: return (imm & 32'hFFFF_F000) | rd << 7 | op;
      4: return bits(imm, 20, 1) << 31 | bits(imm, 1, 10) << 21 | bits(imm, 11, 1) << 20
              | bits(imm, 12, 8) << 12 | rd << 7 | op;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input bit v, input int fmt, input int op, input int f3, input int f7,
                       input int rd, input int rs1, input int rs2, input bit [31:0] imm);
    bus.in_valid  = v;
    bus.in_fmt    = 3'(fmt);
    bus.in_opcode = 7'(op);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_imm    = imm;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_addr  = BASE;
    m_errs  = 0;
    m_err   = 1'b0;
    m_alive = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, m_ready);
    check({tag, "_out_valid"}, bus.out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check({tag, "_out_addr"}, bus.out_addr, m_q[0][63:32]);
      check({tag, "_out_instr"}, bus.out_instr, m_q[0][31:0]);
    end
    check({tag, "_err"}, bus.err, m_err);
    check({tag, "_err_count"}, bus.err_count, m_errs);
  endtask

  // One clock: model the transfers seen before the edge, then compare #1 after it.
  task automatic cycle(input string tag);
    bit        acc, pop, ok;
    bit [31:0] word;
    acc  = bus.in_valid && m_ready;
    pop  = m_q.size() > 0 && bus.out_ready;
    ok   = ref_legal(int'(bus.in_fmt), bus.in_imm);
    word = ref_encode(int'(bus.in_fmt), bus.in_opcode, bus.in_funct3, bus.in_funct7,
                      bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_err = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        if (ok) begin
          m_q.push_back({m_addr, word});
          m_addr += 32'd4;
        end else begin
          m_err = 1'b1;
          if (m_errs < 255) m_errs++;
        end
      end
      m_alive = 1'b1;
    end
    m_ready = m_alive && m_q.size() < DEPTH;
    #1;
    check_outputs(tag);
  endtask

  bit [31:0] bnd [14] = '{32'h7FF, 32'h800, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'hFFE, 32'hFFF,
                          32'h1000, 32'hFFFF_F000, 32'hFFFF_EFFE, 32'h000F_FFFE, 32'h0010_0000,
                          32'hFFF0_0000, 32'hFFEF_FFFE, 32'h0000_0001};

  function automatic bit [31:0] rand_imm();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return $urandom_range(0, 8191) - 32'd4096;
      2: return bnd[$urandom_range(0, 13)];
      3: return $urandom & 32'hFFFF_F000;
      default: return ($urandom_range(0, (1 << 21) - 1) - 32'h0010_0000) & ~32'd1;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");

    rst_n = 1'b1;
    cycle("post_reset");

    // Basic I then S words, consumer always ready.
    bus.out_ready = 1'b1;
    drive(1'b1, 0, 7'h13, 0, 0, 1, 0, 0, 32'd5);
    cycle("i_word");
    check("i_word_instr", bus.out_instr, 32'h0050_0093);
    check("i_word_addr", bus.out_addr, 32'h0000_0000);
    drive(1'b1, 1, 7'h23, 2, 0, 0, 1, 2, 32'd8);
    cycle("s_word");
    check("s_word_instr", bus.out_instr, 32'h0020_A423);
    check("s_word_addr", bus.out_addr, 32'h0000_0004);

    // Out-of-range I immediate is dropped and counted.
    drive(1'b1, 0, 7'h13, 0, 0, 1, 0, 0, 32'd2048);
    cycle("i_bad");
    check("i_bad_err", bus.err, 1'b1);
    check("i_bad_cnt", bus.err_count, 8'd1);
    check("i_bad_nov", bus.out_valid, 1'b0);
    drive(1'b1, 0, 7'h13, 0, 0, 2, 0, 0, 32'd1);
    cycle("after_bad");
    check("after_bad_addr", bus.out_addr, 32'h0000_0008);
    check("after_bad_err", bus.err, 1'b0);

    // J format boundaries.
    drive(1'b1, 4, 7'h6F, 0, 0, 0, 0, 0, 32'd0);
    cycle("j_zero");
    check("j_zero_instr", bus.out_instr, 32'h0000_006F);
    drive(1'b1, 4, 7'h6F, 0, 0, 0, 0, 0, 32'd1);
    cycle("j_odd");
    check("j_odd_err", bus.err, 1'b1);

    // Back-pressure: third word is held until the consumer drains.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5, 7'h33, i, 0, i + 3, 1, 2, 32'h0);
      cycle("bp_fill");
    end
    check("bp_full_ready", bus.in_ready, 1'b0);
    check("bp_head_addr", bus.out_addr, 32'h0000_0010);
    cycle("bp_hold");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      cycle("bp_drain");
    end

    // Asynchronous reset with two words buffered.
    bus.out_ready = 1'b0;
    drive(1'b1, 3, 7'h37, 0, 0, 5, 0, 0, 32'h1234_5000);
    cycle("pre_rst_a");
    cycle("pre_rst_b");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_err_count", bus.err_count, 8'd0);
    cycle("in_rst");
    rst_n = 1'b1;
    cycle("rst_release");
    cycle("rst_first");
    check("rst_first_addr", bus.out_addr, BASE);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 127),
            $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), rand_imm());
      bus.out_ready = $urandom_range(0, 2) != 0;
      cycle("rand");
    end

    // Error counter saturation.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 270; i++) begin
      drive(1'b1, 6 + (i % 2), 7'h13, 0, 0, 0, 0, 0, 32'h0);
      cycle("sat");
    end
    check("sat_err_count", bus.err_count, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, is the address assigned to the first encoded word after reset.
REQ-002 Parameter DEPTH, default 2, is the number of output buffer entries; legal range 2..8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  field set on the in_* ports is valid.
REQ-006 in_ready  output  1  encoder accepts a field set this cycle.
REQ-007 in_fmt  input  3  format code: 000 I (incl. load/jalr), 001 S, 010 B, 011 U, 100 J, 101 R; 110 and 111 are illegal.
REQ-008 in_opcode  input  7  opcode placed in bits [6:0].
REQ-009 in_funct3  input  3  funct3 field; in_funct7  input  7  funct7 field.
REQ-010 in_rd / in_rs1 / in_rs2  input  5 each  register fields.
REQ-011 in_imm  input  32  immediate, as produced by the decoder for the same format.
REQ-012 out_valid  output  1  out_instr/out_addr hold a buffered word.
REQ-013 out_ready  input  1  consumer takes the word this cycle.
REQ-014 out_instr  output  32  encoded instruction; out_addr  output  32  its word address.
REQ-015 err  output  1  one-cycle pulse, the cycle after an illegal field set is accepted.
REQ-016 err_count  output  8  count of illegal field sets since reset, saturating at 255.

Function
REQ-017 A transfer occurs when in_valid and in_ready are both 1; out likewise with out_valid and out_ready.
REQ-018 in_ready SHALL be 1 iff buffer occupancy < DEPTH; it has no combinational dependency on out_ready.
REQ-019 Packing: R = funct7|rs2|rs1|funct3|rd|opcode; I = imm[11:0]|rs1|funct3|rd|opcode; S = imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode; B = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode; U = imm[31:12]|rd|opcode; J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-020 Legality: I/S require imm[31:11] all equal; B requires imm[31:12] all equal and imm[0]=0; U requires imm[11:0]=0; J requires imm[31:20] all equal and imm[0]=0; R ignores in_imm; fmt 110/111 are always illegal.
REQ-021 A legal field set is written to the buffer with the current address counter value, and the counter then increments by 4, wrapping modulo 2^32.
REQ-022 An illegal field set is accepted (consumes the handshake), is not buffered, leaves the address counter unchanged, pulses err, and increments err_count.
REQ-023 Latency: a legal word accepted in cycle N is visible on out_* in cycle N+1 when the buffer was empty.
REQ-024 The buffer is FIFO-ordered; out_instr/out_addr SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous push and pop with occupancy k leaves occupancy k; a pop when empty and a push when full cannot occur.

Reset
REQ-026 While rst_n=0: out_valid=0, in_ready=0, err=0, err_count=0, the address counter is BASE_ADDR, and the buffer is empty.
REQ-027 In-flight buffered words are discarded on reset, and in_ready rises in the first cycle after rst_n deasserts.

Structure
REQ-028 Format codes, the major opcode constants, and the encoded-word record type SHALL reside in shared package riscv_pkg, which the decoder also uses.
REQ-029 The buffer SHALL be sub-module instr_enc_fifo (DEPTH entries of {addr, instr}, with count, full, and empty outputs).

Verification
REQ-030 I fmt, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr 0x00500093, out_addr 0x00000000, next cycle.
REQ-031 S fmt, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8, following REQ-030 -> out_instr 0x0020A423, out_addr 0x00000004.
REQ-032 I fmt, imm=2048 -> err pulses one cycle, err_count=1, no out_valid, and the next legal word is still at the expected address.
REQ-033 out_ready=0 with 3 back-to-back legal inputs -> in_ready=0 after 2 are accepted, and the third is held; raising out_ready drains words in order at addresses +0, +4, +8.
REQ-034 rst_n low for 1 cycle with 2 words buffered -> out_valid=0 immediately, and the next accepted word has out_addr=BASE_ADDR.
REQ-035 J fmt, opcode 0x6F, rd=0, imm=0 -> out_instr 0x0000006F; J fmt with imm=1 -> err pulse.
